// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared word width, RX state encoding and a majority helper.
// Build switch UART_RX_MAJORITY_EN (see uart_rx.sv) enables 3-sample voting.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

package uart_rx_pkg;

  localparam int unsigned DATA_W    = `UART_DATA_WIDTH;
  localparam int unsigned BIT_CTR_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4
  } rx_state_e;

  // Two-of-three vote over consecutive line samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_sync: 2-FF synchronizer for an asynchronous input pin, resets to RST_VAL.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Two flops in series to resolve metastability on d_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with data and framing-error strobes.
// Optional macro UART_RX_MAJORITY_EN: sample decisions vote over the last three
// synchronized line values instead of using a single sample.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_o_v,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_CTR_W-1:0] BIT_LAST = BIT_CTR_W'(DATA_W - 1);

  logic                 rx_s;
  logic                 samp_c;
  rx_state_e            state_q;
  logic [OS_W-1:0]      os_ctr_q;
  logic [BIT_CTR_W-1:0] bit_ctr_q;
  logic [DATA_W-1:0]    shift_q;
  logic [DATA_W-1:0]    data_q;
  logic                 data_v_q;
  logic                 ferr_q;
  logic                 busy_q;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // History of the two previous synchronized samples for voting.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], rx_s};
  end

  assign samp_c = maj3({hist_q, rx_s});
`else
  assign samp_c = rx_s;
`endif

  // Receive FSM: start qualify, data shift, stop check, stuck-low wait.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      os_ctr_q  <= '0;
      bit_ctr_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      data_v_q  <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      data_v_q <= 1'b0;
      ferr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          os_ctr_q  <= '0;
          bit_ctr_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (os_ctr_q == OS_HALF) begin
            os_ctr_q <= '0;
            if (samp_c) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            os_ctr_q <= os_ctr_q + OS_W'(1);
          end
        end
        ST_DATA: begin
          if (os_ctr_q == OS_LAST) begin
            os_ctr_q <= '0;
            shift_q  <= {samp_c, shift_q[DATA_W-1:1]};
            if (bit_ctr_q == BIT_LAST) begin
              bit_ctr_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              bit_ctr_q <= bit_ctr_q + BIT_CTR_W'(1);
            end
          end else begin
            os_ctr_q <= os_ctr_q + OS_W'(1);
          end
        end
        ST_STOP: begin
          if (os_ctr_q == OS_LAST) begin
            os_ctr_q <= '0;
            if (samp_c) begin
              data_q   <= shift_q;
              data_v_q <= 1'b1;
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT;
            end
          end else begin
            os_ctr_q <= os_ctr_q + OS_W'(1);
          end
        end
        ST_WAIT: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign data_o_v    = data_v_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16x oversampling.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned OS = 16;
  localparam int unsigned H  = OS / 2;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              rx   = 1'b1;
  logic [DATA_W-1:0] data_o;
  logic              data_o_v;
  logic              frame_err_o;
  logic              busy_o;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   strobe_cyc[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rx_i        (rx),
    .data_o      (data_o),
    .data_o_v    (data_o_v),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Strobe monitor: pop the scoreboard on every data/error pulse.
  always @(negedge clk) begin
    if (rstn && (data_o_v || frame_err_o)) begin
      chk("strobe_excl", 32'(data_o_v & frame_err_o), 32'd0);
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("strobe_kind", 32'(frame_err_o), 32'(mon_e.err));
        chk("strobe_data", 32'(data_o), 32'(mon_e.data));
      end
      strobe_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n, input int glitch_at);
    for (int j = 0; j < n; j++) begin
      rx = (j == glitch_at) ? ~v : v;
      tick(1);
    end
  endtask

  // Line is left at the stop level so frames can be sent back to back.
  task automatic send(input logic [7:0] b, input int bc, input logic stop_v, input int glitch);
    drive(1'b0, bc, -1);
    for (int k = 0; k < 8; k++) drive(b[k], bc, (k == 0) ? glitch : -1);
    drive(stop_v, bc, -1);
  endtask

  task automatic expect_frame(input logic err, input logic [7:0] d);
    sb.push_back({err, d});
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_v"}, 32'(data_o_v), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] glitch_exp;

    // Reset state
    rstn = 1'b0;
    rx   = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rstn = 1'b1;
    tick(5);

    // Clean frame
    expect_frame(1'b0, 8'hA5);
    send(8'hA5, OS, 1'b1, -1);
    rx = 1'b1;
    tick(2);
    chk("a5_busy_low", 32'(busy_o), 32'd0);
    drain("a5_drain", 50);
    tick(5);

    // False start, then a normal frame
    drive(1'b0, 5, -1);
    chk("false_busy_high", 32'(busy_o), 32'd1);
    rx = 1'b1;
    tick(H + 3);
    chk("false_busy_low", 32'(busy_o), 32'd0);
    tick(10);
    expect_frame(1'b0, 8'h3C);
    send(8'h3C, OS, 1'b1, -1);
    rx = 1'b1;
    drain("3c_drain", 50);
    tick(5);

    // Framing error: data_o must keep the preceding good word
    expect_frame(1'b0, 8'h11);
    send(8'h11, OS, 1'b1, -1);
    rx = 1'b1;
    drain("11_drain", 50);
    tick(5);
    expect_frame(1'b1, 8'h11);
    send(8'h3C, OS, 1'b0, -1);
    drive(1'b0, 40, -1);
    chk("ferr_busy_held", 32'(busy_o), 32'd1);
    chk("ferr_data_hold", 32'(data_o), 32'h11);
    rx = 1'b1;
    tick(6);
    chk("ferr_busy_low", 32'(busy_o), 32'd0);
    drain("ferr_drain", 20);
    tick(5);

    // Back-to-back frames with zero idle
    strobe_cyc.delete();
    expect_frame(1'b0, 8'h00);
    expect_frame(1'b0, 8'hFF);
    send(8'h00, OS, 1'b1, -1);
    send(8'hFF, OS, 1'b1, -1);
    rx = 1'b1;
    tick(20);
    chk("b2b_count", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2)
      chk("b2b_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd160);
    drain("b2b_drain", 20);

    // Skewed bit periods
    expect_frame(1'b0, 8'hC5);
    send(8'hC5, 15, 1'b1, -1);
    rx = 1'b1;
    tick(30);
    drain("skew15_drain", 20);
    expect_frame(1'b0, 8'h96);
    send(8'h96, 17, 1'b1, -1);
    rx = 1'b1;
    tick(30);
    drain("skew17_drain", 20);

    // Reset in the middle of data bit 3
    drive(1'b0, OS, -1);
    drive(1'b1, OS, -1);
    drive(1'b1, OS, -1);
    drive(1'b0, OS, -1);
    drive(1'b1, H, -1);
    rstn = 1'b0;
    tick(2);
    chk_all_zero("midreset");
    rstn = 1'b1;
    rx   = 1'b1;
    tick(30);
    chk("midreset_idle_busy", 32'(busy_o), 32'd0);
    expect_frame(1'b0, 8'h5A);
    send(8'h5A, OS, 1'b1, -1);
    rx = 1'b1;
    drain("5a_drain", 50);
    tick(5);

    // One-cycle glitch at the bit-0 sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h81;
`else
    glitch_exp = 8'h80;
`endif
    expect_frame(1'b0, glitch_exp);
    send(8'h81, OS, 1'b1, 8);
    rx = 1'b1;
    drain("glitch_drain", 50);
    tick(5);
    chk("final_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
